demux8x3_stream: RTL and testbench

//   Registered 1-to-8 stream demultiplexer: the distribution counterpart of the
//   8:1 selector. Accepts one word per cycle with a 3-bit destination select and

---
 rtl/demux8x3_stream_pkg.sv | 21 ++
 rtl/demux8x3_stream_slot.sv | 36 +++
 rtl/demux8x3_stream.sv | 85 ++++++++
 tb/tb_demux8x3_stream.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/demux8x3_stream_pkg.sv
// Shared constants and helpers for the 1-to-8 stream demultiplexer.
//   DEMUX_CH   : number of destination channels
//   DEMUX_SELW : width of the destination select
//   DEMUX_OCCW : width of the occupancy count (must hold 0..DEMUX_CH)
package demux8x3_stream_pkg;

  localparam int DEMUX_CH   = 8;
  localparam int DEMUX_SELW = 3;
  localparam int DEMUX_OCCW = 4;

  // Number of set bits in a channel-wide vector; result fits the occupancy width.
  function automatic logic [DEMUX_OCCW-1:0] popcount_ch(input logic [DEMUX_CH-1:0] vec);
    logic [DEMUX_OCCW-1:0] cnt;
    cnt = {DEMUX_OCCW{1'b0}};
    for (int i = 0; i < DEMUX_CH; i++) begin
      cnt = cnt + {{(DEMUX_OCCW-1){1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/demux8x3_stream_slot.sv
// One-entry holding slot of the stream demultiplexer.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   load     : write din into the slot and mark it valid (wins over drain)
//   drain    : consumer takes the slot this cycle (clears valid unless loaded)
//   din      : word to store on load
//   valid    : slot holds a word
//   dout     : stored word; keeps its last value after a drain
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] din,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);

  // Valid flag and data register; a load on the same edge as a drain refills the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= {WIDTH{1'b0}};
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (drain) begin
      valid <= 1'b0;
    end else begin
      valid <= valid;
    end
  end

endmodule

// File: rtl/demux8x3_stream.sv
// Registered 1-to-8 stream demultiplexer. Each accepted word is parked in the
// one-entry slot named by in_sel until that slot's consumer takes it.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : producer has a word on in_data/in_sel
//   in_ready   : word can be accepted this cycle (independent of in_valid)
//   in_data    : word to route
//   in_sel     : destination channel 0..7
//   out_valid  : bit i set when slot i holds a word
//   out_ready  : bit i set when consumer i takes slot i this cycle
//   out_data   : slot i word at [i*WIDTH +: WIDTH]
//   occupancy  : registered count of full slots, 0..8
module demux8x3_stream
  import demux8x3_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [DEMUX_SELW-1:0]     in_sel,
  output logic [DEMUX_CH-1:0]       out_valid,
  input  logic [DEMUX_CH-1:0]       out_ready,
  output logic [DEMUX_CH*WIDTH-1:0] out_data,
  output logic [DEMUX_OCCW-1:0]     occupancy
);

  logic                  accept_s;
  logic [DEMUX_CH-1:0]   load_s;
  logic [DEMUX_CH-1:0]   drain_s;
  logic [DEMUX_OCCW-1:0] occ_next_s;

  // Ready when the target slot is empty or is being emptied on this same edge.
  always_comb begin
    in_ready = 1'b0;
    if (rst) begin
      in_ready = 1'b0;
    end else begin
      in_ready = !out_valid[in_sel] || out_ready[in_sel];
    end
  end

  // Select decode: only the addressed slot sees a load, and only on a handshake.
  always_comb begin
    accept_s = in_valid && in_ready;
    load_s   = {DEMUX_CH{1'b0}};
    if (accept_s) begin
      load_s = {{(DEMUX_CH-1){1'b0}}, 1'b1} << in_sel;
    end else begin
      load_s = {DEMUX_CH{1'b0}};
    end
  end

  // Drains only count for slots that actually hold a word.
  always_comb begin
    drain_s    = out_valid & out_ready;
    occ_next_s = occupancy + {{(DEMUX_OCCW-1){1'b0}}, accept_s} - popcount_ch(drain_s);
  end

  // Occupancy tracks popcount(out_valid) incrementally; bounded to 0..8 by the slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= {DEMUX_OCCW{1'b0}};
    end else begin
      occupancy <= occ_next_s;
    end
  end

  for (genvar g = 0; g < DEMUX_CH; g++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (load_s[g]),
      .drain(drain_s[g]),
      .din  (in_data),
      .valid(out_valid[g]),
      .dout (out_data[g*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_demux8x3_stream.sv
// Bench for demux8x3_stream: a table of directed vectors with hand-computed
// in_ready/out_valid/occupancy, followed by random traffic. Every cycle is also
// checked against a behavioural model and a per-channel scoreboard of words.
module tb_demux8x3_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [2:0]  in_sel;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [63:0] out_data;
  logic [3:0]  occupancy;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  logic [7:0] mv;
  logic [7:0] mdata [8];
  logic [7:0] sbq [8][$];

  typedef struct {
    logic       r;
    logic       iv;
    logic [7:0] d;
    logic [2:0] s;
    logic [7:0] ordy;
    logic       erdy;
    logic [7:0] eov;
    logic [3:0] eocc;
  } vec_t;

  vec_t vecs[$];

  demux8x3_stream #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic iv, input logic [7:0] d, input logic [2:0] s,
                     input logic [7:0] ordy, input logic erdy, input logic [7:0] eov,
                     input logic [3:0] eocc);
    vec_t v;
    v.r = r; v.iv = iv; v.d = d; v.s = s; v.ordy = ordy;
    v.erdy = erdy; v.eov = eov; v.eocc = eocc;
    vecs.push_back(v);
  endtask

  // One clock: drive after negedge, check in_ready, then check state after the edge.
  task automatic run_cycle(input logic r, input logic iv, input logic [7:0] d,
                           input logic [2:0] s, input logic [7:0] ordy,
                           input bit use_exp, input logic erdy, input logic [7:0] eov,
                           input logic [3:0] eocc, input int idx);
    logic       m_rdy;
    logic       acc;
    logic [7:0] drn;
    @(negedge clk);
    rst = r; in_valid = iv; in_data = d; in_sel = s; out_ready = ordy;
    #1;
    m_rdy = !r && (!mv[s] || ordy[s]);
    acc   = iv && m_rdy;
    drn   = r ? 8'h00 : (mv & ordy);
    check($sformatf("in_ready c%0d", idx), {31'd0, in_ready}, {31'd0, m_rdy});
    if (use_exp) check($sformatf("tbl in_ready v%0d", idx), {31'd0, in_ready}, {31'd0, erdy});
    @(posedge clk);
    #1;
    if (r) begin
      mv = 8'h00;
      for (int i = 0; i < 8; i++) begin
        mdata[i] = 8'h00;
        sbq[i].delete();
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (drn[i]) begin
          if (sbq[i].size() > 0) void'(sbq[i].pop_front());
          mv[i] = 1'b0;
        end
      end
      if (acc) begin
        sbq[s].push_back(d);
        mdata[s] = d;
        mv[s] = 1'b1;
      end
    end
    check($sformatf("out_valid c%0d", idx), {24'd0, out_valid}, {24'd0, mv});
    check($sformatf("occupancy c%0d", idx), {28'd0, occupancy}, $countones(mv));
    if (use_exp) begin
      check($sformatf("tbl out_valid v%0d", idx), {24'd0, out_valid}, {24'd0, eov});
      check($sformatf("tbl occupancy v%0d", idx), {28'd0, occupancy}, {28'd0, eocc});
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("slice%0d c%0d", i, idx), {24'd0, out_data[i*8 +: 8]}, {24'd0, mdata[i]});
      if (mv[i]) begin
        if (sbq[i].size() == 0) begin
          fails++;
          tests++;
          $display("FAIL scoreboard ch%0d c%0d: got valid word expected empty queue", i, idx);
        end else begin
          check($sformatf("sb ch%0d c%0d", i, idx), {24'd0, out_data[i*8 +: 8]}, {24'd0, sbq[i][0]});
        end
      end
    end
  endtask

  initial begin
    logic [7:0] ov;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_sel = 3'd0; out_ready = 8'h00;
    mv = 8'h00;
    for (int i = 0; i < 8; i++) mdata[i] = 8'h00;

    // Reset held two cycles, then released
    add(1'b1, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 8'h00, 4'd0);
    add(1'b1, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 8'h00, 4'd0);
    add(1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b1, 8'h00, 4'd0);
    // Single route into slot 3
    add(1'b0, 1'b1, 8'hA5, 3'd3, 8'h00, 1'b1, 8'h08, 4'd1);
    // Blocked on full slot 3, then accepted with a same-edge drain
    add(1'b0, 1'b1, 8'h5A, 3'd3, 8'h00, 1'b0, 8'h08, 4'd1);
    add(1'b0, 1'b1, 8'h5A, 3'd3, 8'h08, 1'b1, 8'h08, 4'd1);
    // Drain slot 3 with in_valid low: in_ready still reflects slot state
    add(1'b0, 1'b0, 8'h00, 3'd3, 8'h08, 1'b1, 8'h00, 4'd0);
    // Fill all eight slots, then drain all in one cycle
    ov = 8'h00;
    for (int i = 0; i < 8; i++) begin
      ov[i] = 1'b1;
      add(1'b0, 1'b1, 8'h10 + 8'(i), 3'(i), 8'h00, 1'b1, ov, 4'(i + 1));
    end
    add(1'b0, 1'b1, 8'h77, 3'd2, 8'h00, 1'b0, 8'hFF, 4'd8);
    add(1'b0, 1'b0, 8'h00, 3'd0, 8'hFF, 1'b1, 8'h00, 4'd0);
    // Occupancy 5, then one accept and three drains on the same edge
    ov = 8'h00;
    for (int i = 0; i < 5; i++) begin
      ov[i] = 1'b1;
      add(1'b0, 1'b1, 8'h20 + 8'(i), 3'(i), 8'h00, 1'b1, ov, 4'(i + 1));
    end
    add(1'b0, 1'b1, 8'h25, 3'd5, 8'h07, 1'b1, 8'h38, 4'd3);
    // out_ready on empty slots is ignored
    add(1'b0, 1'b0, 8'h00, 3'd0, 8'hC0, 1'b1, 8'h38, 4'd3);
    add(1'b0, 1'b0, 8'h00, 3'd0, 8'hFF, 1'b1, 8'h00, 4'd0);
    // Occupancy 6, then reset mid-stream discards everything
    ov = 8'h00;
    for (int i = 0; i < 6; i++) begin
      ov[i] = 1'b1;
      add(1'b0, 1'b1, 8'h30 + 8'(i), 3'(i), 8'h00, 1'b1, ov, 4'(i + 1));
    end
    add(1'b1, 1'b1, 8'h99, 3'd6, 8'h00, 1'b0, 8'h00, 4'd0);
    add(1'b0, 1'b0, 8'h00, 3'd6, 8'h00, 1'b1, 8'h00, 4'd0);

    for (int k = 0; k < vecs.size(); k++) begin
      run_cycle(vecs[k].r, vecs[k].iv, vecs[k].d, vecs[k].s, vecs[k].ordy,
                1'b1, vecs[k].erdy, vecs[k].eov, vecs[k].eocc, k);
    end

    // Random traffic against the model and scoreboard
    for (int k = 0; k < 400; k++) begin
      run_cycle(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                1'($urandom_range(0, 3) != 0),
                8'($urandom_range(0, 255)),
                3'($urandom_range(0, 7)),
                8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)),
                1'b0, 1'b0, 8'h00, 4'd0, 1000 + k);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
